// File: rtl/csi2_pkt_handler_vc_if.sv
// AXI4-Stream bundle shared by the CSI-2 packet path; master drives everything except tready.
interface axi4_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 2,
    parameter int unsigned USER_W = 1,
    parameter int unsigned ID_W   = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;
    logic [USER_W-1:0]     tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/csi2_pkt_handler_vc.sv
// CSI-2 packet handler: decodes headers, filters long packets by VC/DT, strips header and CRC,
// and emits keyed AXI4-Stream payload lines plus per-VC frame-start/frame-end pulses.
module csi2_pkt_handler_vc #(
    parameter int unsigned NUM_VC       = 4,
    parameter bit          DT_FILTER_EN = 1'b0,
    parameter logic [5:0]  DT_ACCEPT    = 6'h2A
) (
    input  logic              clk_i,
    input  logic              rst_i,
    axi4_stream_if.slave      pkt_i,
    axi4_stream_if.master     pkt_o,
    output logic [NUM_VC-1:0] frame_start_o,
    output logic [NUM_VC-1:0] frame_end_o,
    output logic              drop_o
);
    typedef enum logic [1:0] {StIdle, StPayload, StDrop} state_e;

    state_e            state, state_next;
    logic [16:0]       rem, rem_next;
    logic [16:0]       pay, pay_next;
    logic [1:0]        cur_vc, cur_vc_next;
    logic [NUM_VC-1:0] sof_pend, sof_pend_next;
    logic [NUM_VC-1:0] fs, fs_next, fe, fe_next;
    logic              drop, drop_next;
    logic              out_vld, out_vld_next;
    logic [31:0]       out_data, out_data_next;
    logic [3:0]        out_keep, out_keep_next;
    logic              out_last, out_last_next;
    logic [1:0]        out_dest, out_dest_next;
    logic              out_user, out_user_next;

    logic        in_rdy, fire, accept, vc_sof;
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;

    assign dt     = pkt_i.tdata[5:0];
    assign vc     = pkt_i.tdata[7:6];
    assign wc     = pkt_i.tdata[23:8];
    assign in_rdy = !out_vld || pkt_o.tready;
    assign fire   = pkt_i.tvalid && in_rdy;
    assign accept = (32'(vc) < NUM_VC) && (!DT_FILTER_EN || dt == DT_ACCEPT);

    always_comb begin
        state_next    = state;
        rem_next      = rem;
        pay_next      = pay;
        cur_vc_next   = cur_vc;
        sof_pend_next = sof_pend;
        fs_next       = '0;
        fe_next       = '0;
        drop_next     = 1'b0;
        out_vld_next  = out_vld;
        out_data_next = out_data;
        out_keep_next = out_keep;
        out_last_next = out_last;
        out_dest_next = out_dest;
        out_user_next = out_user;
        vc_sof        = 1'b0;

        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (cur_vc == 2'(v)) vc_sof = sof_pend[v];
        end

        if (out_vld && pkt_o.tready) out_vld_next = 1'b0;

        if (fire) begin
            unique case (state)
                StIdle: begin
                    if (dt <= 6'h0F) begin
                        // Loop bound excludes VCs beyond NUM_VC, so those never pulse.
                        for (int v = 0; v < int'(NUM_VC); v++) begin
                            if (vc == 2'(v)) begin
                                if (dt == 6'h00) begin
                                    fs_next[v]       = 1'b1;
                                    sof_pend_next[v] = 1'b1;
                                end
                                if (dt == 6'h01) fe_next[v] = 1'b1;
                            end
                        end
                    end else begin
                        rem_next    = 17'(wc) + 17'd2;
                        pay_next    = 17'(wc);
                        cur_vc_next = vc;
                        if (accept) begin
                            state_next = StPayload;
                        end else begin
                            state_next = StDrop;
                            drop_next  = 1'b1;
                        end
                    end
                end
                StPayload, StDrop: begin
                    if (rem <= 17'd4) state_next = StIdle;
                    else              rem_next   = rem - 17'd4;
                    if (state == StPayload && pay != 17'd0) begin
                        out_vld_next  = 1'b1;
                        out_data_next = pkt_i.tdata;
                        out_dest_next = cur_vc;
                        out_user_next = vc_sof;
                        out_last_next = (pay <= 17'd4);
                        if (pay >= 17'd4) begin
                            out_keep_next = 4'b1111;
                            pay_next      = pay - 17'd4;
                        end else begin
                            out_keep_next = (4'b0001 << pay[1:0]) - 4'b0001;
                            pay_next      = 17'd0;
                        end
                        for (int v = 0; v < int'(NUM_VC); v++) begin
                            if (cur_vc == 2'(v)) sof_pend_next[v] = 1'b0;
                        end
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= StIdle;
            rem      <= '0;
            pay      <= '0;
            cur_vc   <= '0;
            sof_pend <= '0;
            fs       <= '0;
            fe       <= '0;
            drop     <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
            out_dest <= '0;
            out_user <= 1'b0;
        end else begin
            state    <= state_next;
            rem      <= rem_next;
            pay      <= pay_next;
            cur_vc   <= cur_vc_next;
            sof_pend <= sof_pend_next;
            fs       <= fs_next;
            fe       <= fe_next;
            drop     <= drop_next;
            out_vld  <= out_vld_next;
            out_data <= out_data_next;
            out_keep <= out_keep_next;
            out_last <= out_last_next;
            out_dest <= out_dest_next;
            out_user <= out_user_next;
        end
    end

    assign pkt_i.tready  = in_rdy;
    assign pkt_o.tvalid  = out_vld;
    assign pkt_o.tdata   = out_data;
    assign pkt_o.tkeep   = out_keep;
    assign pkt_o.tstrb   = out_keep;
    assign pkt_o.tlast   = out_last;
    assign pkt_o.tid     = '0;
    assign pkt_o.tdest   = out_dest;
    assign pkt_o.tuser   = out_user;
    assign frame_start_o = fs;
    assign frame_end_o   = fe;
    assign drop_o        = drop;
endmodule

// File: tb/tb_csi2_pkt_handler_vc.sv
// Bench: table of per-cycle vectors for two configurations, plus backpressure and reset sequences.
module tb_csi2_pkt_handler_vc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_stream_if a_in ();
    axi4_stream_if a_out ();
    axi4_stream_if b_in ();
    axi4_stream_if b_out ();

    logic [3:0] a_fs, a_fe;
    logic [1:0] b_fs, b_fe;
    logic       a_drop, b_drop;

    csi2_pkt_handler_vc #(.NUM_VC(4), .DT_FILTER_EN(1'b0), .DT_ACCEPT(6'h2A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .pkt_i(a_in.slave), .pkt_o(a_out.master),
        .frame_start_o(a_fs), .frame_end_o(a_fe), .drop_o(a_drop)
    );

    csi2_pkt_handler_vc #(.NUM_VC(2), .DT_FILTER_EN(1'b1), .DT_ACCEPT(6'h2B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .pkt_i(b_in.slave), .pkt_o(b_out.master),
        .frame_start_o(b_fs), .frame_end_o(b_fe), .drop_o(b_drop)
    );

    typedef struct {
        bit          sel;
        logic [31:0] din;
        logic        vld;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic [1:0]  dest;
        logic [3:0]  fs;
        logic [3:0]  fe;
        logic        drop;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t nv(bit sel, logic [31:0] din, logic [3:0] fs, logic [3:0] fe,
                                logic drop);
        vec_t r;
        r = '{sel: sel, din: din, vld: 1'b0, keep: 4'h0, last: 1'b0, user: 1'b0, dest: 2'd0,
              fs: fs, fe: fe, drop: drop};
        return r;
    endfunction

    function automatic vec_t ov(bit sel, logic [31:0] din, logic [3:0] keep, logic last,
                                logic user, logic [1:0] dest);
        vec_t r;
        r = '{sel: sel, din: din, vld: 1'b1, keep: keep, last: last, user: user, dest: dest,
              fs: 4'h0, fe: 4'h0, drop: 1'b0};
        return r;
    endfunction

    task automatic run_row(input int idx, input vec_t r);
        logic [17:0] got, exp;
        logic [31:0] gdata;
        @(negedge clk);
        a_in.tvalid = (r.sel == 1'b0);
        b_in.tvalid = (r.sel == 1'b1);
        a_in.tdata  = r.din;
        b_in.tdata  = r.din;
        @(posedge clk);
        #1;
        if (r.sel == 1'b0) begin
            got = {a_out.tvalid, a_out.tkeep, a_out.tlast, a_out.tuser, a_out.tdest,
                   a_fs, a_fe, a_drop};
            gdata = a_out.tdata;
        end else begin
            got = {b_out.tvalid, b_out.tkeep, b_out.tlast, b_out.tuser, b_out.tdest,
                   {2'b00, b_fs}, {2'b00, b_fe}, b_drop};
            gdata = b_out.tdata;
        end
        // Output fields are only meaningful while tvalid is high.
        if (!r.vld) got[16:9] = '0;
        exp = {r.vld, r.keep, r.last, r.user, r.dest, r.fs, r.fe, r.drop};
        check($sformatf("row%0d_flags", idx), 64'(got), 64'(exp));
        if (r.vld) check($sformatf("row%0d_data", idx), 64'(gdata), 64'(r.din));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, rx, stall_left, cyc;
        bit stall_done, in_hs, out_hs;

        a_in.tvalid = 1'b0; a_in.tdata = '0; a_in.tkeep = '0; a_in.tstrb = '0;
        a_in.tlast  = 1'b0; a_in.tid   = '0; a_in.tdest = '0; a_in.tuser = '0;
        b_in.tvalid = 1'b0; b_in.tdata = '0; b_in.tkeep = '0; b_in.tstrb = '0;
        b_in.tlast  = 1'b0; b_in.tid   = '0; b_in.tdest = '0; b_in.tuser = '0;
        a_out.tready = 1'b1;
        b_out.tready = 1'b1;

        #2;
        check("reset_a", 64'({a_out.tvalid, a_out.tdata, a_out.tkeep, a_out.tlast,
                              a_out.tdest, a_out.tuser, a_fs, a_fe, a_drop}), 64'd0);
        check("reset_b", 64'({b_out.tvalid, b_out.tdata, b_out.tkeep, b_out.tlast,
                              b_out.tdest, b_out.tuser, b_fs, b_fe, b_drop}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Configuration A: NUM_VC=4, no DT filtering.
        vecs.push_back(nv(0, 32'h0000_0040, 4'b0010, 4'b0000, 0));   // FS VC1
        vecs.push_back(nv(0, 32'h0000_00C1, 4'b0000, 4'b1000, 0));   // FE VC3
        vecs.push_back(nv(0, 32'h0000_0002, 4'b0000, 4'b0000, 0));   // LS, silent
        vecs.push_back(nv(0, 32'h0000_0000, 4'b0001, 4'b0000, 0));   // FS VC0
        vecs.push_back(nv(0, 32'h0000_062A, 4'b0000, 4'b0000, 0));   // WC=6 VC0
        vecs.push_back(ov(0, 32'h1111_1111, 4'b1111, 0, 1, 2'd0));
        vecs.push_back(ov(0, 32'h2222_2222, 4'b0011, 1, 0, 2'd0));
        vecs.push_back(nv(0, 32'h0000_082A, 4'b0000, 4'b0000, 0));   // WC=8 VC0
        vecs.push_back(ov(0, 32'hA0A0_A001, 4'b1111, 0, 0, 2'd0));
        vecs.push_back(ov(0, 32'hA0A0_A002, 4'b1111, 1, 0, 2'd0));
        vecs.push_back(nv(0, 32'hCCCC_0000, 4'b0000, 4'b0000, 0));   // CRC only
        vecs.push_back(nv(0, 32'h0000_07AA, 4'b0000, 4'b0000, 0));   // WC=7 VC2
        vecs.push_back(ov(0, 32'hB0B0_B001, 4'b1111, 0, 0, 2'd2));
        vecs.push_back(ov(0, 32'hB0B0_B002, 4'b0111, 1, 0, 2'd2));
        vecs.push_back(nv(0, 32'hCCCC_0001, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(0, 32'h0000_002A, 4'b0000, 4'b0000, 0));   // WC=0
        vecs.push_back(nv(0, 32'hCCCC_0002, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(0, 32'h0000_0040, 4'b0010, 4'b0000, 0));   // FS VC1 again
        vecs.push_back(nv(0, 32'h0000_046A, 4'b0000, 4'b0000, 0));   // WC=4 VC1
        vecs.push_back(ov(0, 32'hC1C1_C1C1, 4'b1111, 1, 1, 2'd1));
        vecs.push_back(nv(0, 32'hCCCC_0003, 4'b0000, 4'b0000, 0));
        // Configuration B: NUM_VC=2, only DT=0x2B forwarded.
        vecs.push_back(nv(1, 32'h0000_042A, 4'b0000, 4'b0000, 1));   // DT mismatch
        vecs.push_back(nv(1, 32'hDEAD_0001, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(1, 32'hDEAD_0002, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(1, 32'h0000_00C0, 4'b0000, 4'b0000, 0));   // FS VC3, ignored
        vecs.push_back(nv(1, 32'h0000_04EB, 4'b0000, 4'b0000, 1));   // VC3 out of range
        vecs.push_back(nv(1, 32'hDEAD_0003, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(1, 32'hDEAD_0004, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(1, 32'h0000_0040, 4'b0010, 4'b0000, 0));   // FS VC1
        vecs.push_back(nv(1, 32'h0000_046B, 4'b0000, 4'b0000, 0));
        vecs.push_back(ov(1, 32'hD1D1_D1D1, 4'b1111, 1, 1, 2'd1));
        vecs.push_back(nv(1, 32'hCCCC_0004, 4'b0000, 4'b0000, 0));
        vecs.push_back(nv(1, 32'h0000_0041, 4'b0000, 4'b0010, 0));   // FE VC1

        for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);
        @(negedge clk);
        a_in.tvalid = 1'b0;
        b_in.tvalid = 1'b0;

        // Backpressure: WC=64 line, downstream stalls 5 cycles after the 5th output beat.
        sent = 0; rx = 0; stall_left = 0; cyc = 0; stall_done = 0;
        while ((sent < 18 || rx < 16) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            a_in.tvalid = (sent < 18);
            a_in.tdata  = (sent == 0) ? 32'h0000_402A : 32'(sent);
            if (!stall_done && rx == 5) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            a_out.tready = (stall_left == 0);
            #3;
            if (stall_left > 0) begin
                check("bp_in_ready_low", 64'(a_in.tready), 64'd0);
                check("bp_hold", 64'({a_out.tvalid, a_out.tdata, a_out.tkeep, a_out.tlast}),
                      64'({1'b1, 32'(rx + 1), 4'b1111, 1'b0}));
                stall_left--;
            end
            in_hs  = a_in.tvalid && a_in.tready;
            out_hs = a_out.tvalid && a_out.tready;
            if (out_hs) begin
                check($sformatf("bp_beat%0d", rx),
                      64'({a_out.tdata, a_out.tkeep, a_out.tlast, a_out.tuser, a_out.tdest}),
                      64'({32'(rx + 1), 4'b1111, (rx == 15), 1'b0, 2'd0}));
                rx++;
            end
            if (in_hs) sent++;
            @(posedge clk);
        end
        check("bp_complete", 64'({16'(sent), 16'(rx)}), 64'({16'd18, 16'd16}));
        @(negedge clk);
        a_in.tvalid  = 1'b0;
        a_out.tready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_no_extra", 64'(a_out.tvalid), 64'd0);

        // Reset in the middle of a WC=32 payload, then re-sync on a FS header.
        @(negedge clk);
        a_in.tvalid = 1'b1;
        a_in.tdata  = 32'h0000_202A;
        @(negedge clk);
        a_in.tdata  = 32'h5555_0001;
        @(negedge clk);
        a_in.tdata  = 32'h5555_0002;
        @(negedge clk);
        a_in.tvalid = 1'b0;
        check("rst_pre_valid", 64'({a_out.tvalid, a_out.tdata}), 64'({1'b1, 32'h5555_0002}));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 64'({a_out.tvalid, a_out.tdata, a_out.tkeep, a_out.tlast,
                                      a_out.tdest, a_out.tuser, a_fs, a_fe, a_drop}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_in.tvalid = 1'b1;
        a_in.tdata  = 32'h0000_0080;
        @(posedge clk);
        #1;
        check("resync_fs", 64'({a_out.tvalid, a_fs}), 64'({1'b0, 4'b0100}));
        @(negedge clk);
        a_in.tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("resync_fs_width", 64'(a_fs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/csi2_pkt_handler_vc.md
Name:
csi2_pkt_handler_vc

Overview:
- Multi-virtual-channel CSI-2 packet handler.
- Sits between the lane-merge/ECC stage (32-bit beats, one header per beat) and the pixel unpacker.
- Decodes short and long packet headers and emits per-VC frame-start/frame-end pulses.
- Filters long packets by VC and data type, strips header and CRC, and produces correctly keyed AXI4-Stream lines tagged with VC (tdest) and start-of-frame (tuser).
- Honours downstream backpressure through a registered output stage.

Parameters:
- NUM_VC, 4, number of supported virtual channels (1..4); packets with VC >= NUM_VC are dropped.
- DT_FILTER_EN, 0, 1: forward only long packets whose DT == DT_ACCEPT; 0: forward every long packet.
- DT_ACCEPT, 6'h2A, accepted long-packet data type when DT_FILTER_EN=1.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous, active-high reset.
- pkt_i, axi4_stream_if.slave, 32b tdata, raw CSI-2 beats; tlast/tkeep ignored.
- pkt_o, axi4_stream_if.master, 32b tdata / 4b tkeep+tstrb / 2b tdest / 1b tuser, payload lines.
- frame_start_o, out, NUM_VC, one-cycle pulse per VC on FS header.
- frame_end_o, out, NUM_VC, one-cycle pulse per VC on FE header.
- drop_o, out, 1, one-cycle pulse when a long-packet header is rejected.

Behaviour:
- Header fields: DT=tdata[5:0], VC=tdata[7:6], WC=tdata[23:8]. DT<=0x0F is a short packet (single beat); DT>0x0F is a long packet.
- Input handshake: pkt_i.tready = !out_vld || pkt_o.tready. A beat is consumed only on tvalid&&tready.
- Output register stage: pkt_o.tvalid, tdata, tkeep, tlast, tdest and tuser are held stable while tvalid&&!tready. tstrb = tkeep. tid = 0.
- States:
  - IDLE: the next beat is a header.
    - Short packet: stay in IDLE.
    - Long, accepted: go to PAYLOAD.
    - Long, rejected (VC>=NUM_VC, or DT mismatch when filtering): go to DROP and pulse drop_o.
  - PAYLOAD: forward payload beats.
  - DROP: consume beats with no output.
  - On header accept, load rem = WC+2 (17 bits, payload plus 2 CRC bytes) and pay = WC.
- Per consumed beat in PAYLOAD/DROP:
  - If rem<=4, return to IDLE; else rem -= 4.
  - Beats after the header = ceil((WC+2)/4).
- Output in PAYLOAD, only when pay>0:
  - tkeep = 4'b1111 if pay>=4, else low pay bits set (pay=1→0001, 2→0011, 3→0111).
  - tlast = (pay<=4). Then pay -= min(pay,4).
  - Trailing CRC-only beats (WC%4 in {0,3}) produce no output.
  - WC=0 long packet: one beat consumed, no output.
- tdest = VC of the packet.
- Start of frame: sof_pend[vc] is set by FS on vc and cleared on the first output beat of that vc. tuser = sof_pend[vc] on that beat, 0 otherwise.
- Frame flags:
  - FS (DT=0x00) or FE (DT=0x01) accepted in IDLE with VC<NUM_VC pulses frame_start_o[VC] / frame_end_o[VC].
  - The pulse occurs one cycle after the handshake, is one cycle wide, and is independent of pkt_o.tready.
  - VC>=NUM_VC produces no pulse.
  - Other short packets (LS/LE/generic) are consumed silently.
- Latency: an input payload beat appears on pkt_o the cycle after its handshake.
- Reset values: state=IDLE; rem=0; pay=0; sof_pend=0; pkt_o.tvalid=0; tdata=0; tkeep=0; tlast=0; tdest=0; tuser=0; frame_start_o=0; frame_end_o=0; drop_o=0.
- Reset mid-packet: outputs clear immediately. The first beat accepted after reset release is treated as a header.
- WC arithmetic is 17 bits, so WC=16'hFFFF does not overflow.

Test Plan:
- FS header tdata=32'h0000_0040 (VC1, NUM_VC=4) -> frame_start_o=4'b0010 for exactly one cycle, no pkt_o beat; FE 32'h0000_00C1 -> frame_end_o=4'b1000.
- FS VC0, then long DT=0x2A WC=6 plus 2 beats -> 2 output beats: beat 1 tkeep=1111, tuser=1, tdest=0; beat 2 tkeep=0011, tlast=1. Next line on VC0 has tuser=0.
- WC=8 (3 beats after header) -> 2 output beats, last tkeep=1111, tlast=1, CRC beat swallowed. WC=7 (3 beats) -> last tkeep=0111. WC=0 (1 beat) -> no output, back to IDLE.
- DT_FILTER_EN=1, DT_ACCEPT=0x2B: long DT=0x2A WC=4 -> drop_o pulse, 2 beats consumed with tready=1, no pkt_o beats. Likewise NUM_VC=2 with VC=3 -> dropped, no frame flags.
- pkt_o.tready=0 for 5 cycles mid-line of WC=64 -> pkt_i.tready=0 after the buffered beat, pkt_o held stable, all 16 beats delivered in order with no duplication.
- Assert rst_i during PAYLOAD of WC=32 -> all outputs 0 asynchronously. After release, a FS header beat produces a frame_start pulse, confirming re-sync.
